// File: rtl/diag_bus_arbiter.sv
// ---------------------------------------------------------------------------
// diag_bus_arbiter
//
// Arbitrates ownership of the on-board RAM between the target CPU bus and the
// diagnostics SPI engine. A halt request stalls the CPU through RDY on a phi2
// falling edge. The RAM port is handed to diagnostics only once enough
// consecutive stalled read cycles have been seen, or once phi2 has been quiet
// for PHI2_TIMEOUT cycles. Ownership is returned on the next phi2 falling edge
// (or timeout) after halt drops.
//
// Ports:
//   fpga_clk, fpga_reset      system clock, asynchronous active-low reset
//   halt                      diagnostics halt request (level, fpga_clk domain)
//   phi2, cpu_rwb             CPU clock and read/write (async, synchronised here)
//   cpu_ram_cs, cpu_address,
//   cpu_data                  CPU-side RAM request
//   diag_address, diag_data,
//   diag_we, diag_cs          diagnostics-side RAM request
//   ram_address, ram_data_out,
//   ram_we, ram_cs            registered RAM port
//   rdy                       CPU RDY (1 = run)
//   granted                   1 = diagnostics owns the RAM
// ---------------------------------------------------------------------------
module diag_bus_arbiter #(
  parameter int SYNC_STAGES  = 2,
  parameter int SETTLE_PHI2  = 2,
  parameter int PHI2_TIMEOUT = 1024
) (
  input  logic        fpga_clk,
  input  logic        fpga_reset,
  input  logic        halt,
  input  logic        phi2,
  input  logic        cpu_rwb,
  input  logic        cpu_ram_cs,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_data,
  input  logic [15:0] diag_address,
  input  logic [7:0]  diag_data,
  input  logic        diag_we,
  input  logic        diag_cs,
  output logic [15:0] ram_address,
  output logic [7:0]  ram_data_out,
  output logic        ram_we,
  output logic        ram_cs,
  output logic        rdy,
  output logic        granted
);

  localparam int TW = $clog2(PHI2_TIMEOUT + 1);
  localparam int CW = $clog2(SETTLE_PHI2 + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(PHI2_TIMEOUT - 1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(SETTLE_PHI2 - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    GRANTED = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t                 state_r;
  logic [SYNC_STAGES-1:0] phi2_sync_r;
  logic [SYNC_STAGES-1:0] rwb_sync_r;
  logic                   phi2_d_r;
  logic                   stalled_r;
  logic [CW-1:0]          count_r;
  logic [TW-1:0]          tmo_r;

  logic          phi2_s;
  logic          rwb_s;
  logic          fall_s;
  logic          any_edge_s;
  logic          cpu_we_s;
  logic          tmo_hit_s;
  logic          settle_hit_s;
  logic [TW-1:0] tmo_next_s;

  // Synchronise the CPU-side phi2 and rwb and keep a delayed phi2 for edges.
  always_ff @(posedge fpga_clk or negedge fpga_reset) begin
    if (!fpga_reset) begin
      phi2_sync_r <= {SYNC_STAGES{1'b0}};
      rwb_sync_r  <= {SYNC_STAGES{1'b1}};
      phi2_d_r    <= 1'b0;
    end else begin
      phi2_sync_r[0] <= phi2;
      rwb_sync_r[0]  <= cpu_rwb;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        phi2_sync_r[i] <= phi2_sync_r[i-1];
        rwb_sync_r[i]  <= rwb_sync_r[i-1];
      end
      phi2_d_r <= phi2_s;
    end
  end

  assign phi2_s     = phi2_sync_r[SYNC_STAGES-1];
  assign rwb_s      = rwb_sync_r[SYNC_STAGES-1];
  assign fall_s     = phi2_d_r & ~phi2_s;
  assign any_edge_s = phi2_d_r ^ phi2_s;
  // CPU writes only strobe the RAM during the high phase of phi2.
  assign cpu_we_s   = cpu_ram_cs & ~rwb_s & phi2_s;
  // A quiet phi2 for PHI2_TIMEOUT cycles means the CPU clock has stopped.
  assign tmo_hit_s  = ~any_edge_s & (tmo_r == TMO_LAST);
  // The edge that completes the required run of stalled reads.
  assign settle_hit_s = fall_s & stalled_r & rwb_s & (count_r == COUNT_LAST);

  // Saturating quiet-phi2 counter, cleared by any phi2 edge.
  always_comb begin
    tmo_next_s = tmo_r;
    if (any_edge_s) begin
      tmo_next_s = {TW{1'b0}};
    end else if (tmo_r != TMO_LAST) begin
      tmo_next_s = tmo_r + TW'(1);
    end else begin
      tmo_next_s = tmo_r;
    end
  end

  // Ownership FSM with registered RDY, grant flag and RAM port.
  // Any transition that changes the mux source loads ram_cs/ram_we as 0 so a
  // write strobe never straddles the ownership hand-over.
  always_ff @(posedge fpga_clk or negedge fpga_reset) begin
    if (!fpga_reset) begin
      state_r      <= RUN;
      stalled_r    <= 1'b0;
      count_r      <= {CW{1'b0}};
      tmo_r        <= {TW{1'b0}};
      rdy          <= 1'b1;
      granted      <= 1'b0;
      ram_cs       <= 1'b0;
      ram_we       <= 1'b0;
      ram_address  <= 16'h0000;
      ram_data_out <= 8'h00;
    end else begin
      case (state_r)
        RUN: begin
          rdy          <= 1'b1;
          granted      <= 1'b0;
          ram_address  <= cpu_address;
          ram_data_out <= cpu_data;
          ram_cs       <= cpu_ram_cs;
          ram_we       <= cpu_we_s;
          if (halt) begin
            state_r   <= STALL;
            stalled_r <= 1'b0;
            count_r   <= {CW{1'b0}};
            tmo_r     <= {TW{1'b0}};
          end else begin
            tmo_r <= tmo_next_s;
          end
        end
        STALL: begin
          granted <= 1'b0;
          if (!halt) begin
            state_r      <= RELEASE;
            tmo_r        <= {TW{1'b0}};
            ram_address  <= cpu_address;
            ram_data_out <= cpu_data;
            ram_cs       <= 1'b0;
            ram_we       <= 1'b0;
          end else if (settle_hit_s || tmo_hit_s) begin
            state_r      <= GRANTED;
            granted      <= 1'b1;
            rdy          <= 1'b0;
            tmo_r        <= {TW{1'b0}};
            ram_address  <= diag_address;
            ram_data_out <= diag_data;
            ram_cs       <= 1'b0;
            ram_we       <= 1'b0;
          end else begin
            // CPU writes still pass through: NMOS parts ignore RDY on writes.
            ram_address  <= cpu_address;
            ram_data_out <= cpu_data;
            ram_cs       <= cpu_ram_cs;
            ram_we       <= cpu_we_s;
            tmo_r        <= tmo_next_s;
            if (fall_s && !stalled_r) begin
              // First falling edge only asserts the stall; it is not counted.
              rdy       <= 1'b0;
              stalled_r <= 1'b1;
            end else if (fall_s && rwb_s) begin
              count_r <= count_r + CW'(1);
            end else if (fall_s) begin
              count_r <= {CW{1'b0}};
            end else begin
              count_r <= count_r;
            end
          end
        end
        GRANTED: begin
          rdy <= 1'b0;
          if (!halt) begin
            state_r      <= RELEASE;
            granted      <= 1'b0;
            tmo_r        <= {TW{1'b0}};
            ram_address  <= cpu_address;
            ram_data_out <= cpu_data;
            ram_cs       <= 1'b0;
            ram_we       <= 1'b0;
          end else begin
            granted      <= 1'b1;
            tmo_r        <= tmo_next_s;
            ram_address  <= diag_address;
            ram_data_out <= diag_data;
            ram_cs       <= diag_cs;
            ram_we       <= diag_we;
          end
        end
        RELEASE: begin
          granted      <= 1'b0;
          ram_address  <= cpu_address;
          ram_data_out <= cpu_data;
          ram_cs       <= 1'b0;
          ram_we       <= 1'b0;
          if (fall_s || tmo_hit_s) begin
            state_r <= RUN;
            rdy     <= 1'b1;
            tmo_r   <= {TW{1'b0}};
          end else begin
            tmo_r <= tmo_next_s;
          end
        end
        default: begin
          state_r <= RUN;
          rdy     <= 1'b1;
          granted <= 1'b0;
          ram_cs  <= 1'b0;
          ram_we  <= 1'b0;
          tmo_r   <= {TW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_diag_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_diag_bus_arbiter
//
// Drives a randomised phi2/CPU bus and halt/diagnostics traffic into
// diag_bus_arbiter and compares every output each cycle against a behavioural
// model of the ownership rules, with a few hand-computed timing points.
// ---------------------------------------------------------------------------
module tb_diag_bus_arbiter;

  localparam int SS = 2;
  localparam int ST = 2;
  localparam int TO = 1024;

  localparam int M_RUN   = 0;
  localparam int M_STALL = 1;
  localparam int M_GRANT = 2;
  localparam int M_REL   = 3;

  logic        fpga_clk = 1'b0;
  logic        fpga_reset;
  logic        halt;
  logic        phi2;
  logic        cpu_rwb;
  logic        cpu_ram_cs;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_data;
  logic [15:0] diag_address;
  logic [7:0]  diag_data;
  logic        diag_we;
  logic        diag_cs;
  logic [15:0] ram_address;
  logic [7:0]  ram_data_out;
  logic        ram_we;
  logic        ram_cs;
  logic        rdy;
  logic        granted;

  int  checks = 0;
  int  errors = 0;
  bit  cmp_en = 1'b0;
  bit  phi2_run = 1'b1;
  bit  rd_only = 1'b1;
  bit  diag_rand = 1'b0;
  int  wr_req = 0;
  int  wr_done = 0;

  // model state
  int          m_mode;
  bit          m_dropped;
  int          m_reads;
  int          m_idle;
  bit          ph_hist[$];
  bit          rw_hist[$];
  logic        e_rdy, e_granted, e_cs, e_we;
  logic [15:0] e_addr;
  logic [7:0]  e_data;

  diag_bus_arbiter #(.SYNC_STAGES(SS), .SETTLE_PHI2(ST), .PHI2_TIMEOUT(TO)) dut (
    .fpga_clk(fpga_clk), .fpga_reset(fpga_reset), .halt(halt), .phi2(phi2),
    .cpu_rwb(cpu_rwb), .cpu_ram_cs(cpu_ram_cs), .cpu_address(cpu_address),
    .cpu_data(cpu_data), .diag_address(diag_address), .diag_data(diag_data),
    .diag_we(diag_we), .diag_cs(diag_cs), .ram_address(ram_address),
    .ram_data_out(ram_data_out), .ram_we(ram_we), .ram_cs(ram_cs),
    .rdy(rdy), .granted(granted)
  );

  always #5 fpga_clk = ~fpga_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_RUN; m_dropped = 1'b0; m_reads = 0; m_idle = 0;
    ph_hist.delete(); rw_hist.delete();
    for (int i = 0; i <= SS; i++) begin
      ph_hist.push_back(1'b0);
      rw_hist.push_back(1'b1);
    end
    e_rdy = 1'b1; e_granted = 1'b0; e_cs = 1'b0; e_we = 1'b0;
    e_addr = 16'h0000; e_data = 8'h00;
  endtask

  // One fpga_clk step of the ownership rules, using the pin history to see
  // what the synchronised phi2/rwb look like at this edge.
  task automatic model_step();
    bit ps, pd, rs, fell, moved, timed_out;
    int nxt;
    ps = ph_hist[SS-1]; pd = ph_hist[SS]; rs = rw_hist[SS-1];
    fell = pd & ~ps;
    moved = pd ^ ps;
    timed_out = !moved && (m_idle >= TO - 1);
    nxt = m_mode;
    case (m_mode)
      M_RUN: if (halt) begin nxt = M_STALL; m_dropped = 1'b0; m_reads = 0; end
      M_STALL: begin
        if (!halt) nxt = M_REL;
        else if (fell) begin
          if (!m_dropped) begin m_dropped = 1'b1; e_rdy = 1'b0; end
          else if (rs) begin m_reads++; if (m_reads >= ST) nxt = M_GRANT; end
          else m_reads = 0;
        end else if (timed_out) begin nxt = M_GRANT; e_rdy = 1'b0; end
      end
      M_GRANT: if (!halt) nxt = M_REL;
      M_REL: if (fell || timed_out) begin nxt = M_RUN; e_rdy = 1'b1; end
      default: nxt = M_RUN;
    endcase
    // RAM port: who drives it after this edge, with strobes suppressed on hand-over
    if (nxt == M_GRANT) begin
      e_addr = diag_address; e_data = diag_data;
      e_cs = (m_mode == M_GRANT) ? diag_cs : 1'b0;
      e_we = (m_mode == M_GRANT) ? diag_we : 1'b0;
    end else if (nxt == M_REL || m_mode == M_REL) begin
      e_addr = cpu_address; e_data = cpu_data; e_cs = 1'b0; e_we = 1'b0;
    end else begin
      e_addr = cpu_address; e_data = cpu_data; e_cs = cpu_ram_cs;
      e_we = cpu_ram_cs & ~rs & ps;
    end
    if (nxt != m_mode || moved) m_idle = 0;
    else if (m_idle < TO - 1) m_idle++;
    m_mode = nxt;
    e_granted = (nxt == M_GRANT);
    ph_hist.push_front(phi2); void'(ph_hist.pop_back());
    rw_hist.push_front(cpu_rwb); void'(rw_hist.pop_back());
  endtask

  // reference model process
  initial begin
    model_reset();
    forever begin
      @(posedge fpga_clk or negedge fpga_reset);
      if (!fpga_reset) model_reset();
      else model_step();
    end
  end

  // per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge fpga_clk); #1;
      if (cmp_en) begin
        chk("rdy", 32'(rdy), 32'(e_rdy));
        chk("granted", 32'(granted), 32'(e_granted));
        chk("ram_cs", 32'(ram_cs), 32'(e_cs));
        chk("ram_we", 32'(ram_we), 32'(e_we));
        chk("ram_address", 32'(ram_address), 32'(e_addr));
        chk("ram_data_out", 32'(ram_data_out), 32'(e_data));
      end
    end
  end

  // phi2 / CPU bus generator: random half periods, bus values change on phi2 rise
  initial begin
    int half_left;
    half_left = 4;
    phi2 = 1'b0; cpu_rwb = 1'b1; cpu_ram_cs = 1'b0; cpu_address = 16'h0000; cpu_data = 8'h00;
    forever begin
      @(negedge fpga_clk);
      if (half_left > 0) half_left--;
      else if (phi2) begin
        phi2 = 1'b0;
        half_left = $urandom_range(4, 12);
      end else if (phi2_run) begin
        phi2 = 1'b1;
        half_left = $urandom_range(4, 12);
        if (wr_done < wr_req * 3) begin cpu_rwb = 1'b0; wr_done++; end
        else if (rd_only) cpu_rwb = 1'b1;
        else cpu_rwb = ($urandom_range(0, 9) < 3) ? 1'b0 : 1'b1;
        cpu_ram_cs  = ($urandom_range(0, 3) != 0);
        cpu_address = 16'($urandom);
        cpu_data    = 8'($urandom);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge fpga_clk);
      if (diag_rand) begin
        diag_address = 16'($urandom); diag_data = 8'($urandom);
        diag_we = 1'($urandom_range(0, 1)); diag_cs = 1'($urandom_range(0, 1));
      end
    end
  endtask

  // bounded wait for rdy (sel=0) or granted (sel=1) to reach val
  task automatic wait_out(input string name, input bit sel, input logic val, input int budget);
    int n;
    n = 0;
    while (((sel ? granted : rdy) !== val) && n < budget) begin
      @(negedge fpga_clk); n++;
    end
    chk(name, 32'(sel ? granted : rdy), 32'(val));
  endtask

  initial begin
    bit saw_grant;
    fpga_reset = 1'b0; halt = 1'b0;
    diag_address = 16'h0000; diag_data = 8'h00; diag_we = 1'b0; diag_cs = 1'b0;
    repeat (3) @(negedge fpga_clk);
    #1;
    chk("reset_rdy", 32'(rdy), 32'd1);
    chk("reset_granted", 32'(granted), 32'd0);
    chk("reset_ram_cs", 32'(ram_cs), 32'd0);
    chk("reset_ram_we", 32'(ram_we), 32'd0);
    chk("reset_ram_address", 32'(ram_address), 32'd0);
    chk("reset_ram_data", 32'(ram_data_out), 32'd0);
    @(negedge fpga_clk);
    fpga_reset = 1'b1;
    cmp_en = 1'b1;

    // basic halt and resume, reads only
    cycles(60);
    halt = 1'b1;
    wait_out("basic_rdy_low", 1'b0, 1'b0, 400);
    wait_out("basic_granted", 1'b1, 1'b1, 400);
    cycles(10);
    halt = 1'b0;
    @(posedge fpga_clk); #1;
    chk("basic_granted_drop", 32'(granted), 32'd0);
    chk("basic_release_cs", 32'(ram_cs), 32'd0);
    chk("basic_release_we", 32'(ram_we), 32'd0);
    wait_out("basic_rdy_back", 1'b0, 1'b1, 400);

    // halt during a burst of write cycles
    cycles(30);
    wr_req++;
    halt = 1'b1;
    wait_out("writes_granted", 1'b1, 1'b1, 800);
    cycles(5);
    halt = 1'b0;
    wait_out("writes_rdy_back", 1'b0, 1'b1, 400);

    // aborted halt: dropped shortly after the stall takes hold
    cycles(30);
    halt = 1'b1;
    wait_out("abort_rdy_low", 1'b0, 1'b0, 400);
    saw_grant = 1'b0;
    repeat ($urandom_range(1, 6)) begin @(negedge fpga_clk); saw_grant |= granted; end
    halt = 1'b0;
    for (int i = 0; i < 400 && rdy !== 1'b1; i++) begin
      @(negedge fpga_clk); saw_grant |= granted;
    end
    chk("abort_no_grant", 32'(saw_grant), 32'd0);
    chk("abort_rdy_back", 32'(rdy), 32'd1);

    // stopped CPU clock: grant and release by timeout
    phi2_run = 1'b0;
    cycles(40);
    halt = 1'b1;
    repeat (TO) @(posedge fpga_clk);
    #1;
    chk("stop_not_yet_granted", 32'(granted), 32'd0);
    @(posedge fpga_clk); #1;
    chk("stop_granted", 32'(granted), 32'd1);
    chk("stop_rdy_low", 32'(rdy), 32'd0);
    // diagnostics path latency
    @(negedge fpga_clk);
    diag_address = 16'h1234; diag_data = 8'hA5; diag_we = 1'b1; diag_cs = 1'b1;
    @(posedge fpga_clk); #1;
    chk("diag_address", 32'(ram_address), 32'h1234);
    chk("diag_data", 32'(ram_data_out), 32'hA5);
    chk("diag_we_pulse", 32'(ram_we), 32'd1);
    @(negedge fpga_clk);
    diag_we = 1'b0;
    @(posedge fpga_clk); #1;
    chk("diag_we_one_cycle", 32'(ram_we), 32'd0);
    @(negedge fpga_clk);
    diag_cs = 1'b0;
    halt = 1'b0;
    @(posedge fpga_clk); #1;
    chk("stop_granted_drop", 32'(granted), 32'd0);
    repeat (TO - 1) @(posedge fpga_clk);
    #1;
    chk("stop_rdy_still_low", 32'(rdy), 32'd0);
    @(posedge fpga_clk); #1;
    chk("stop_rdy_back", 32'(rdy), 32'd1);
    phi2_run = 1'b1;

    // reset while granted with a write in flight
    cycles(30);
    halt = 1'b1;
    wait_out("rst_granted", 1'b1, 1'b1, 600);
    @(negedge fpga_clk);
    diag_address = 16'hBEEF; diag_data = 8'h5A; diag_we = 1'b1; diag_cs = 1'b1;
    @(posedge fpga_clk); #1;
    chk("rst_pre_we", 32'(ram_we), 32'd1);
    @(negedge fpga_clk);
    fpga_reset = 1'b0;
    #1;
    chk("rst_rdy", 32'(rdy), 32'd1);
    chk("rst_granted_low", 32'(granted), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_cs", 32'(ram_cs), 32'd0);
    chk("rst_ram_address", 32'(ram_address), 32'd0);
    @(negedge fpga_clk);
    halt = 1'b0;
    diag_address = 16'h0000; diag_data = 8'h00; diag_we = 1'b0; diag_cs = 1'b0;
    @(negedge fpga_clk);
    fpga_reset = 1'b1;

    // randomised traffic checked against the model every cycle
    diag_rand = 1'b1;
    rd_only = 1'b0;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 5) == 0) wr_req++;
      if (it % 13 == 7) phi2_run = 1'b0;
      halt = ($urandom_range(0, 2) != 0);
      cycles($urandom_range(10, 250));
      if (!phi2_run) begin
        cycles(TO + 80);
        phi2_run = 1'b1;
      end
    end
    halt = 1'b0;
    cycles(TO + 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
